// File: rtl/vga_pkg.sv
// Shared VGA timing defaults (640x480 @ 60 Hz), counter type and 3-bit colour constants.
// Included by vga_axis_counter and vga_sync_gen.
package vga_pkg;

  localparam int H_VISIBLE_DEF = 640;
  localparam int H_FP_DEF      = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BP_DEF      = 48;
  localparam int V_VISIBLE_DEF = 480;
  localparam int V_FP_DEF      = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BP_DEF      = 33;

  localparam int H_TOTAL = H_VISIBLE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int V_TOTAL = V_VISIBLE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  localparam int CNT_W = 10;
  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [2:0]       rgb_t;

  // {R,G,B}
  localparam rgb_t BLACK   = 3'b000;
  localparam rgb_t BLUE    = 3'b001;
  localparam rgb_t GREEN   = 3'b010;
  localparam rgb_t CYAN    = 3'b011;
  localparam rgb_t RED     = 3'b100;
  localparam rgb_t MAGENTA = 3'b101;
  localparam rgb_t YELLOW  = 3'b110;
  localparam rgb_t WHITE   = 3'b111;

  // True when lo <= c < hi.
  function automatic logic in_window(cnt_t c, cnt_t lo, cnt_t hi);
    return (c >= lo) && (c < hi);
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis (horizontal or vertical): a wrapping position counter with a
// registered sync output that is aligned with the count.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int   VISIBLE  = H_VISIBLE_DEF,
  parameter int   FP       = H_FP_DEF,
  parameter int   SYNC     = H_SYNC_DEF,
  parameter int   BP       = H_BP_DEF,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output cnt_t count,
  output logic wrap,
  output logic sync
);

  localparam int   TOTAL   = VISIBLE + FP + SYNC + BP;
  localparam cnt_t LAST    = cnt_t'(TOTAL - 1);
  localparam cnt_t SYNC_LO = cnt_t'(VISIBLE + FP);
  localparam cnt_t SYNC_HI = cnt_t'(VISIBLE + FP + SYNC);

  cnt_t count_next;

  assign wrap = enable && (count == LAST);

  // NOTE: the default assignment first keeps this block purely combinational (no latch).
  always_comb begin
    count_next = count;
    if (enable) count_next = wrap ? '0 : count + 1'b1;
  end

  // Sync is decoded from the next count so the registered pulse lines up with count.
  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
      sync  <= ~SYNC_POL;
    end else begin
      count <= count_next;
      sync  <= in_window(count_next, SYNC_LO, SYNC_HI) ? SYNC_POL : ~SYNC_POL;
    end
  end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel-clock divider, x/y scan counters, registered syncs and frame tick.
// Define VGA_SYNC_OUT_REG_EN to add one pixel-wide output register on vga_rgb/hsync/vsync.
module vga_sync_gen
  import vga_pkg::*;
#(
  parameter int   CLK_DIV   = 2,
  parameter int   H_VISIBLE = H_VISIBLE_DEF,
  parameter int   H_FP      = H_FP_DEF,
  parameter int   H_SYNC    = H_SYNC_DEF,
  parameter int   H_BP      = H_BP_DEF,
  parameter int   V_VISIBLE = V_VISIBLE_DEF,
  parameter int   V_FP      = V_FP_DEF,
  parameter int   V_SYNC    = V_SYNC_DEF,
  parameter int   V_BP      = V_BP_DEF,
  parameter logic SYNC_POL  = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] rgb_in,
  output logic [9:0] xpos,
  output logic [9:0] ypos,
  output logic       active,
  output logic       tick,
  output logic       pix_stb,
  output logic       hsync,
  output logic       vsync,
  output logic [2:0] vga_rgb
);

  localparam logic [1:0] DIV_LAST     = 2'(CLK_DIV - 1);
  localparam cnt_t       H_VIS_END    = cnt_t'(H_VISIBLE);
  localparam cnt_t       V_VIS_END    = cnt_t'(V_VISIBLE);
  localparam cnt_t       V_LAST_VIS   = cnt_t'(V_VISIBLE - 1);

  logic [1:0] div;
  logic       h_wrap;
  logic       v_wrap_unused;
  logic       h_sync;
  logic       v_sync;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) div <= '0;
    else       div <= (div == DIV_LAST) ? '0 : div + 2'd1;
  end

  // Gated by reset so that CLK_DIV=1 (divider pinned at its last value) stays quiet in reset.
  assign pix_stb = (div == DIV_LAST) && !reset;

  vga_axis_counter #(
    .VISIBLE (H_VISIBLE),
    .FP      (H_FP),
    .SYNC    (H_SYNC),
    .BP      (H_BP),
    .SYNC_POL(SYNC_POL)
  ) u_h_axis (
    .clk   (clk),
    .reset (reset),
    .enable(pix_stb),
    .count (xpos),
    .wrap  (h_wrap),
    .sync  (h_sync)
  );

  vga_axis_counter #(
    .VISIBLE (V_VISIBLE),
    .FP      (V_FP),
    .SYNC    (V_SYNC),
    .BP      (V_BP),
    .SYNC_POL(SYNC_POL)
  ) u_v_axis (
    .clk   (clk),
    .reset (reset),
    .enable(h_wrap),
    .count (ypos),
    .wrap  (v_wrap_unused),
    .sync  (v_sync)
  );

  assign active = (xpos < H_VIS_END) && (ypos < V_VIS_END);

  // Fires on the edge that moves the scan onto (x=0, y=V_VISIBLE): first cycle of vertical blanking.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) tick <= 1'b0;
    else       tick <= h_wrap && (ypos == V_LAST_VIS);
  end

`ifdef VGA_SYNC_OUT_REG_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vga_rgb <= BLACK;
      hsync   <= ~SYNC_POL;
      vsync   <= ~SYNC_POL;
    end else if (pix_stb) begin
      vga_rgb <= active ? rgb_in : BLACK;
      hsync   <= h_sync;
      vsync   <= v_sync;
    end
  end
`else
  // active decodes (0,0) as visible during reset, so blank explicitly there.
  assign vga_rgb = (active && !reset) ? rgb_in : BLACK;
  assign hsync   = h_sync;
  assign vsync   = v_sync;
`endif

endmodule
